// File: rtl/i2c_sensor_poller.sv
// rtl/i2c_sensor_poller.sv - Wishbone sequencer that polls an I2C sensor through the OpenCores i2c_master_top
`timescale 1ns/1ps
module i2c_sensor_poller #(
  parameter logic [15:0] PRESCALE    = 16'd99,
  parameter logic [6:0]  DEV_ADDR    = 7'h48,
  parameter logic [7:0]  REG_ADDR    = 8'h00,
  parameter int          NBYTES      = 2,
  parameter int unsigned POLL_PERIOD = 0,
  parameter int unsigned TIP_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic [2:0]            wb_adr_o,
  output logic [7:0]            wb_dat_o,
  input  logic [7:0]            wb_dat_i,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i,
  output logic [8*NBYTES-1:0]   sample_o,
  output logic                  sample_valid_o,
  output logic                  err_nack_o,
  output logic                  err_al_o,
  output logic                  busy_o
);

  localparam int SW = 8 * NBYTES;

  // Core register addresses
  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXRX   = 3'd3;
  localparam logic [2:0] ADR_CRSR   = 3'd4;

  // Command bytes and status bit positions
  localparam logic [7:0] CTR_EN    = 8'h80;
  localparam logic [7:0] CR_STA_WR = 8'h90;
  localparam logic [7:0] CR_WR     = 8'h10;
  localparam logic [7:0] CR_RD     = 8'h20;
  localparam logic [7:0] CR_RD_END = 8'h68;
  localparam logic [7:0] CR_STO    = 8'h40;
  localparam int SR_RXACK = 7;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  // Steps 0..2 are the address/pointer writes, 3.. are the data reads
  localparam logic [2:0] STEP_ADDRR = 3'd2;
  localparam logic [2:0] LAST_STEP  = 3'(NBYTES + 2);

  localparam bit          POLL_EN   = (POLL_PERIOD != 0);
  localparam logic [31:0] POLL_LAST = POLL_EN ? 32'(POLL_PERIOD - 1) : 32'd0;

  typedef enum logic [3:0] {
    S_INIT0,
    S_INIT1,
    S_INIT2,
    S_IDLE,
    S_TXR,
    S_CR,
    S_WAIT,
    S_RXR,
    S_STOP
  } state_t;

  state_t        r_state, w_state_n;
  logic [2:0]    r_step, w_step_n;
  logic [31:0]   r_tip_cnt, w_tip_cnt_n;
  logic [31:0]   r_poll_cnt;
  logic          r_cyc, w_cyc_n;
  logic          r_we, w_we_n;
  logic [2:0]    r_adr, w_adr_n;
  logic [7:0]    r_dat, w_dat_n;
  logic [SW-1:0] r_shift, w_shift_n;
  logic [SW-1:0] r_sample, w_sample_n;
  logic          r_valid, w_valid_n;
  logic          r_busy, w_busy_n;
  logic          r_err_nack, w_err_nack_n;
  logic          r_err_al, w_err_al_n;

  logic          w_timer_hit;
  logic          w_trig;
  logic          w_accept;
  logic          w_rd_step;
  logic          w_last_step;
  logic [SW-1:0] w_shift_in;
  logic [7:0]    w_txr_byte;
  logic [7:0]    w_cr_byte;
  logic          w_acc_we;
  logic [2:0]    w_acc_adr;
  logic [7:0]    w_acc_dat;

  assign w_timer_hit = POLL_EN && (r_poll_cnt == POLL_LAST);
  assign w_trig      = start_i | w_timer_hit;
  assign w_accept    = (r_state == S_IDLE) && w_trig;
  assign w_rd_step   = (r_step > STEP_ADDRR);
  assign w_last_step = (r_step == LAST_STEP);
  // New byte enters at the LSB so the first byte received ends in the MSBs
  assign w_shift_in  = SW'({r_shift, wb_dat_i});

  // Byte written to TXR for the current write step
  always_comb begin
    w_txr_byte = {DEV_ADDR, 1'b1};
    case (r_step)
      3'd0:    w_txr_byte = {DEV_ADDR, 1'b0};
      3'd1:    w_txr_byte = REG_ADDR;
      default: w_txr_byte = {DEV_ADDR, 1'b1};
    endcase
  end

  // Command written to CR for the current step; the final read NACKs and stops
  always_comb begin
    w_cr_byte = CR_RD;
    case (r_step)
      3'd0:    w_cr_byte = CR_STA_WR;
      3'd1:    w_cr_byte = CR_WR;
      3'd2:    w_cr_byte = CR_STA_WR;
      default: w_cr_byte = w_last_step ? CR_RD_END : CR_RD;
    endcase
  end

  // Wishbone access each bus state performs when it launches
  always_comb begin
    w_acc_we  = 1'b1;
    w_acc_adr = ADR_CRSR;
    w_acc_dat = 8'h00;
    case (r_state)
      S_INIT0: begin w_acc_adr = ADR_PRERLO; w_acc_dat = PRESCALE[7:0];  end
      S_INIT1: begin w_acc_adr = ADR_PRERHI; w_acc_dat = PRESCALE[15:8]; end
      S_INIT2: begin w_acc_adr = ADR_CTR;    w_acc_dat = CTR_EN;         end
      S_TXR:   begin w_acc_adr = ADR_TXRX;   w_acc_dat = w_txr_byte;     end
      S_CR:    begin w_acc_adr = ADR_CRSR;   w_acc_dat = w_cr_byte;      end
      S_WAIT:  begin w_acc_we  = 1'b0;       w_acc_adr = ADR_CRSR;       end
      S_RXR:   begin w_acc_we  = 1'b0;       w_acc_adr = ADR_TXRX;       end
      S_STOP:  begin w_acc_adr = ADR_CRSR;   w_acc_dat = CR_STO;         end
      default: ;
    endcase
  end

  // Next-state logic: every non-IDLE state is one Wishbone access; the state
  // advances on ack, which also drops cyc so the next access sees an idle cycle
  always_comb begin
    w_state_n    = r_state;
    w_step_n     = r_step;
    w_tip_cnt_n  = r_tip_cnt;
    w_cyc_n      = r_cyc;
    w_we_n       = r_we;
    w_adr_n      = r_adr;
    w_dat_n      = r_dat;
    w_shift_n    = r_shift;
    w_sample_n   = r_sample;
    w_valid_n    = 1'b0;
    w_busy_n     = r_busy;
    w_err_nack_n = r_err_nack;
    w_err_al_n   = r_err_al;

    if (r_state == S_IDLE) begin
      if (w_trig) begin
        w_state_n    = S_TXR;
        w_step_n     = 3'd0;
        w_shift_n    = '0;
        w_busy_n     = 1'b1;
        w_err_nack_n = 1'b0;
        w_err_al_n   = 1'b0;
      end
    end else if (!r_cyc) begin
      w_cyc_n = 1'b1;
      w_we_n  = w_acc_we;
      w_adr_n = w_acc_adr;
      w_dat_n = w_acc_dat;
    end else if (wb_ack_i) begin
      w_cyc_n = 1'b0;
      w_we_n  = 1'b0;
      w_adr_n = 3'd0;
      w_dat_n = 8'h00;
      case (r_state)
        S_INIT0: w_state_n = S_INIT1;
        S_INIT1: w_state_n = S_INIT2;
        S_INIT2: w_state_n = S_IDLE;
        S_TXR:   w_state_n = S_CR;
        S_CR: begin
          w_state_n   = S_WAIT;
          w_tip_cnt_n = 32'd0;
        end
        S_WAIT: begin
          if (wb_dat_i[SR_TIP]) begin
            // Still transferring: poll again unless the budget is spent
            if ((r_tip_cnt + 32'd1) >= 32'(TIP_TIMEOUT)) begin
              w_err_al_n = 1'b1;
              w_state_n  = S_STOP;
            end else begin
              w_tip_cnt_n = r_tip_cnt + 32'd1;
            end
          end else if (wb_dat_i[SR_AL]) begin
            // Core has already released the bus, so no STOP
            w_err_al_n = 1'b1;
            w_busy_n   = 1'b0;
            w_state_n  = S_IDLE;
          end else if (w_rd_step) begin
            w_state_n = S_RXR;
          end else if (wb_dat_i[SR_RXACK]) begin
            w_err_nack_n = 1'b1;
            w_state_n    = S_STOP;
          end else begin
            w_step_n  = r_step + 3'd1;
            w_state_n = (r_step == STEP_ADDRR) ? S_CR : S_TXR;
          end
        end
        S_RXR: begin
          w_shift_n = w_shift_in;
          if (w_last_step) begin
            w_sample_n = w_shift_in;
            w_valid_n  = 1'b1;
            w_busy_n   = 1'b0;
            w_state_n  = S_IDLE;
          end else begin
            w_step_n  = r_step + 3'd1;
            w_state_n = S_CR;
          end
        end
        S_STOP: begin
          w_busy_n  = 1'b0;
          w_state_n = S_IDLE;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_INIT0;
      r_step     <= 3'd0;
      r_tip_cnt  <= 32'd0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= 3'd0;
      r_dat      <= 8'h00;
      r_shift    <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_err_nack <= 1'b0;
      r_err_al   <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_step     <= w_step_n;
      r_tip_cnt  <= w_tip_cnt_n;
      r_cyc      <= w_cyc_n;
      r_we       <= w_we_n;
      r_adr      <= w_adr_n;
      r_dat      <= w_dat_n;
      r_shift    <= w_shift_n;
      r_sample   <= w_sample_n;
      r_valid    <= w_valid_n;
      r_busy     <= w_busy_n;
      r_err_nack <= w_err_nack_n;
      r_err_al   <= w_err_al_n;
    end
  end

  // Free-running poll timer; wraps on its own hit and restarts on an accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_poll_cnt <= 32'd0;
    end else if (!POLL_EN || w_timer_hit || w_accept) begin
      r_poll_cnt <= 32'd0;
    end else begin
      r_poll_cnt <= r_poll_cnt + 32'd1;
    end
  end

  assign wb_cyc_o       = r_cyc;
  assign wb_stb_o       = r_cyc;
  assign wb_we_o        = r_we;
  assign wb_adr_o       = r_adr;
  assign wb_dat_o       = r_dat;
  assign sample_o       = r_sample;
  assign sample_valid_o = r_valid;
  assign busy_o         = r_busy;
  assign err_nack_o     = r_err_nack;
  assign err_al_o       = r_err_al;

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// tb/tb_i2c_sensor_poller.sv - directed self-checking bench for i2c_sensor_poller
`timescale 1ns/1ps
module tb_i2c_sensor_poller;

  localparam int PERIOD = 3000;
  localparam int TIPTO  = 8;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic [15:0] sample_o;
  logic        sample_valid_o;
  logic        err_nack_o;
  logic        err_al_o;
  logic        busy_o;

  i2c_sensor_poller #(
    .PRESCALE    (16'd99),
    .DEV_ADDR    (7'h48),
    .REG_ADDR    (8'h00),
    .NBYTES      (2),
    .POLL_PERIOD (PERIOD),
    .TIP_TIMEOUT (TIPTO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_dat_i       (wb_dat_i),
    .wb_we_o        (wb_we_o),
    .wb_stb_o       (wb_stb_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_ack_i       (wb_ack_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .err_nack_o     (err_nack_o),
    .err_al_o       (err_al_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the I2C core's Wishbone slave plus the sensor behind it
  logic       m_clr, m_absent, m_al_mode, m_hang;
  logic [7:0] m_bytes [0:3];
  logic       m_ack;
  logic [7:0] m_dat, m_rxr;
  logic       m_rxack, m_al;
  int         m_tip_left, m_rd_idx, nw, n_sta, n_sr;
  logic [2:0] wl_adr [0:63];
  logic [7:0] wl_dat [0:63];

  assign wb_ack_i = m_ack;
  assign wb_dat_i = m_dat;

  always @(posedge clk) begin
    if (m_clr) begin
      m_ack <= 1'b0; m_dat <= 8'h00; m_rxr <= 8'h00; m_rxack <= 1'b0; m_al <= 1'b0;
      m_tip_left <= 0; m_rd_idx <= 0; nw <= 0; n_sta <= 0; n_sr <= 0;
    end else begin
      m_ack <= wb_cyc_o && wb_stb_o && !m_ack;
      if (wb_cyc_o && wb_stb_o && !m_ack) begin
        if (wb_we_o) begin
          if (nw < 64) begin
            wl_adr[nw] <= wb_adr_o;
            wl_dat[nw] <= wb_dat_o;
          end
          nw <= nw + 1;
          if (wb_adr_o == 3'd4 && (wb_dat_o[7] || wb_dat_o[5] || wb_dat_o[4])) begin
            m_tip_left <= 2;
            m_al       <= m_al_mode;
            if (wb_dat_o[7]) n_sta <= n_sta + 1;
            m_rxack <= wb_dat_o[4] && wb_dat_o[7] && m_absent;
            if (wb_dat_o[5]) begin
              m_rxr    <= m_bytes[m_rd_idx[1:0]];
              m_rd_idx <= m_rd_idx + 1;
            end
          end
        end else if (wb_adr_o == 3'd4) begin
          n_sr  <= n_sr + 1;
          m_dat <= {m_rxack, 1'b0, m_al, 3'b000, (m_tip_left > 0) || m_hang, 1'b0};
          if (m_tip_left > 0) m_tip_left <= m_tip_left - 1;
        end else begin
          m_dat <= (wb_adr_o == 3'd3) ? m_rxr : 8'h00;
        end
      end
    end
  end

  // Sample-strobe monitor
  int          cyc_cnt = 0, n_valid = 0, n_busy_at_valid = 0;
  int          last_valid_cyc = 0, prev_valid_cyc = 0;
  logic [15:0] sample_at_valid = 16'h0;

  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (sample_valid_o) begin
      n_valid         <= n_valid + 1;
      prev_valid_cyc  <= last_valid_cyc;
      last_valid_cyc  <= cyc_cnt;
      sample_at_valid <= sample_o;
      if (busy_o) n_busy_at_valid <= n_busy_at_valid + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic clear_model();
    m_clr = 1'b1;
    @(negedge clk);
    m_clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (busy_o && k < max) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(busy_o), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_init(input string tag);
    logic [10:0] exp_init [0:2];
    exp_init[0] = 11'h063; exp_init[1] = 11'h100; exp_init[2] = 11'h280;
    check_eq({tag, "_nw"}, 32'(nw), 32'd3);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("%s_w%0d", tag, i), 32'({wl_adr[i], wl_dat[i]}), 32'(exp_init[i]));
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  logic [10:0] exp_xfer [0:7];
  int          n0, k;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_xfer[0] = 11'h390; exp_xfer[1] = 11'h490; exp_xfer[2] = 11'h300; exp_xfer[3] = 11'h410;
    exp_xfer[4] = 11'h391; exp_xfer[5] = 11'h490; exp_xfer[6] = 11'h420; exp_xfer[7] = 11'h468;
    rst = 1'b0; m_clr = 1'b1; start_i = 1'b0;
    m_absent = 1'b0; m_al_mode = 1'b0; m_hang = 1'b0;
    m_bytes[0] = 8'hAB; m_bytes[1] = 8'hCD; m_bytes[2] = 8'hAB; m_bytes[3] = 8'hCD;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_wb", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}), 32'd0);
    check_eq("rst_sample", 32'(sample_o), 32'd0);
    check_eq("rst_flags", 32'({sample_valid_o, err_nack_o, err_al_o, busy_o}), 32'd0);

    // Init sequence after release
    rst = 1'b1; m_clr = 1'b0;
    repeat (40) @(negedge clk);
    check_init("init");

    // Normal sample AB CD
    clear_model();
    pulse_start();
    check_eq("busy_rise", 32'(busy_o), 32'd1);
    n0 = n_valid;
    wait_idle("idle_abcd", 500);
    check_eq("sample_abcd", 32'(sample_o), 32'h0000ABCD);
    check_eq("strobe_abcd", 32'(sample_at_valid), 32'h0000ABCD);
    check_eq("nvalid_abcd", 32'(n_valid - n0), 32'd1);
    check_eq("nw_abcd", 32'(nw), 32'd8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("xfer_w%0d", i), 32'({wl_adr[i], wl_dat[i]}), 32'(exp_xfer[i]));
    check_eq("err_abcd", 32'({err_nack_o, err_al_o}), 32'd0);

    // start_i while busy is dropped
    clear_model();
    m_bytes[0] = 8'h12; m_bytes[1] = 8'h34;
    n0 = n_valid;
    pulse_start();
    repeat (20) @(negedge clk);
    check_eq("busy_mid", 32'(busy_o), 32'd1);
    pulse_start();
    wait_idle("idle_mid", 500);
    repeat (30) @(negedge clk);
    check_eq("nvalid_mid", 32'(n_valid - n0), 32'd1);
    check_eq("nsta_mid", 32'(n_sta), 32'd2);
    check_eq("nw_mid", 32'(nw), 32'd8);
    check_eq("sample_mid", 32'(sample_o), 32'h00001234);

    // Absent slave -> NACK, STOP, sample held
    clear_model();
    m_absent = 1'b1;
    n0 = n_valid;
    pulse_start();
    wait_idle("idle_nack", 500);
    check_eq("err_nack", 32'({err_nack_o, err_al_o}), 32'd2);
    check_eq("nw_nack", 32'(nw), 32'd3);
    check_eq("stop_nack", 32'({wl_adr[2], wl_dat[2]}), 32'h440);
    check_eq("sample_nack", 32'(sample_o), 32'h00001234);
    check_eq("nvalid_nack", 32'(n_valid - n0), 32'd0);

    // Next start clears the sticky flag
    clear_model();
    m_absent = 1'b0;
    m_bytes[0] = 8'h55; m_bytes[1] = 8'h66;
    pulse_start();
    check_eq("nack_clr", 32'(err_nack_o), 32'd0);
    wait_idle("idle_5566", 500);
    check_eq("sample_5566", 32'(sample_o), 32'h00005566);

    // Arbitration lost -> err_al, no STOP
    clear_model();
    m_al_mode = 1'b1;
    pulse_start();
    wait_idle("idle_al", 500);
    m_al_mode = 1'b0;
    check_eq("err_al", 32'({err_nack_o, err_al_o}), 32'd1);
    check_eq("nw_al", 32'(nw), 32'd2);
    check_eq("sample_al", 32'(sample_o), 32'h00005566);

    // TIP never clears -> timeout after TIPTO polls, STOP written
    clear_model();
    m_hang = 1'b1;
    pulse_start();
    wait_idle("idle_to", 500);
    m_hang = 1'b0;
    check_eq("err_to", 32'({err_nack_o, err_al_o}), 32'd1);
    check_eq("nsr_to", 32'(n_sr), 32'(TIPTO));
    check_eq("nw_to", 32'(nw), 32'd3);
    check_eq("stop_to", 32'({wl_adr[2], wl_dat[2]}), 32'h440);

    // Reset during RD0 wait
    clear_model();
    m_bytes[0] = 8'h77; m_bytes[1] = 8'h88;
    pulse_start();
    k = 0;
    while (nw < 7 && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check_eq("rd0_cmd", 32'({wl_adr[6], wl_dat[6]}), 32'h420);
    #2;
    rst = 1'b0; m_clr = 1'b1;
    #1;
    check_eq("arst_cyc", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
    check_eq("arst_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1; m_clr = 1'b0;
    repeat (40) @(negedge clk);
    check_init("reinit");
    clear_model();
    pulse_start();
    wait_idle("idle_7788", 500);
    check_eq("sample_7788", 32'(sample_o), 32'h00007788);

    // Automatic polling with start_i idle
    clear_model();
    m_bytes[0] = 8'h9A; m_bytes[1] = 8'hBC; m_bytes[2] = 8'h9A; m_bytes[3] = 8'hBC;
    n0 = n_valid;
    k = 0;
    while (n_valid < n0 + 2 && k < 3 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check_eq("npoll", 32'(n_valid - n0), 32'd2);
    check_eq("poll_gap", 32'(last_valid_cyc - prev_valid_cyc), 32'(PERIOD));
    check_eq("sample_poll", 32'(sample_o), 32'h00009ABC);
    check_eq("busy_at_valid", 32'(n_busy_at_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
